// File: rtl/param_register_file.sv
// rtl/param_register_file.sv - parametrised integer register file with pending-write scoreboard
// Optional macro PARAM_REGFILE_BYPASS_EN: same-cycle write-to-read forwarding on all read ports.
module param_register_file #(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    parameter int SP_IDX = 2,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(32'h20),
    localparam int AW = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  issue_en,
    input  logic [AW-1:0]         issue_rd,
    output logic [AW:0]           pending_cnt
);

`ifdef PARAM_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic             wr_valid;
    logic             issue_valid;
    logic             same_dst;
    logic             cnt_inc;
    logic             cnt_dec;

    // Register 0 is hardwired: neither writes nor issues to it have any effect.
    assign wr_valid    = wr_en && (wr_addr != '0);
    assign issue_valid = issue_en && (issue_rd != '0);
    assign same_dst    = issue_valid && wr_valid && (issue_rd == wr_addr);

    // A write whose destination is re-issued on the same edge keeps the bit set.
    assign cnt_inc = issue_valid && !busy[issue_rd];
    assign cnt_dec = wr_valid && busy[wr_addr] && !same_dst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            if (wr_valid) begin
                regs[wr_addr] <= wr_data;
                busy[wr_addr] <= 1'b0;
            end
            // Issued after the clear so a new producer supersedes the completing one.
            if (issue_valid) begin
                busy[issue_rd] <= 1'b1;
            end
            pending_cnt <= pending_cnt + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign addr = rd_addr[p*AW +: AW];

        always_comb begin
            data = (addr == '0) ? '0 : regs[addr];
            bsy  = busy[addr];
            if (BYPASS && !rst && wr_valid && (addr == wr_addr)) begin
                data = wr_data;
                bsy  = same_dst;
            end
        end

        assign rd_data[p*XLEN +: XLEN] = data;
        assign rd_busy[p]              = bsy;
    end

endmodule

// File: tb/tb_param_register_file.sv
// tb/tb_param_register_file.sv - scoreboard bench for param_register_file against a behavioural model
module tb_param_register_file;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW = 5;
    localparam int SP_IDX = 2;
    localparam logic [XLEN-1:0] SP_INIT = 32'h20;

    logic                  clk;
    logic                  rst;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_busy;
    logic                  issue_en;
    logic [AW-1:0]         issue_rd;
    logic [AW:0]           pending_cnt;

    param_register_file #(
        .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .SP_IDX(SP_IDX), .SP_INIT(SP_INIT)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .pending_cnt(pending_cnt)
    );

    typedef struct {
        logic [NREAD*XLEN-1:0] d;
        logic [NREAD-1:0]      b;
        logic [AW:0]           c;
        string                 tag;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    // Architectural view: register values and a set of outstanding destinations.
    logic [XLEN-1:0] mreg [NREGS];
    bit              mbusy [NREGS];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d expectations pending", q.size());
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            mreg[i]  = (i == SP_IDX) ? SP_INIT : '0;
            mbusy[i] = 1'b0;
        end
    endtask

    task automatic apply_edge();
        if (rst) begin
            model_reset();
        end else begin
            if (wr_en && wr_addr != 0) begin
                mreg[wr_addr]  = wr_data;
                mbusy[wr_addr] = 1'b0;
            end
            if (issue_en && issue_rd != 0) mbusy[issue_rd] = 1'b1;
        end
    endtask

    function automatic exp_t predict(input string tag);
        exp_t e;
        int   n = 0;
        for (int i = 0; i < NREGS; i++) n += int'(mbusy[i]);
        e.c = (AW+1)'(n);
        e.tag = tag;
        for (int p = 0; p < NREAD; p++) begin
            logic [AW-1:0] a;
            a = rd_addr[p*AW +: AW];
            e.d[p*XLEN +: XLEN] = (a == 0) ? '0 : mreg[a];
            e.b[p] = mbusy[a];
`ifdef PARAM_REGFILE_BYPASS_EN
            if (!rst && wr_en && wr_addr != 0 && a == wr_addr) begin
                e.d[p*XLEN +: XLEN] = wr_data;
                e.b[p] = issue_en && (issue_rd == wr_addr);
            end
`endif
        end
        return e;
    endfunction

    task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa,
                         input logic [XLEN-1:0] wd, input logic [AW-1:0] ra1,
                         input logic [AW-1:0] ra0, input logic ie, input logic [AW-1:0] ir);
        @(posedge clk);
        apply_edge();
        #1;
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr = {ra1, ra0}; issue_en = ie; issue_rd = ir;
    endtask

    task automatic step(input logic r, input logic we, input logic [AW-1:0] wa,
                        input logic [XLEN-1:0] wd, input logic [AW-1:0] ra1,
                        input logic [AW-1:0] ra0, input logic ie, input logic [AW-1:0] ir,
                        input string tag);
        drive(r, we, wa, wd, ra1, ra0, ie, ir);
        q.push_back(predict(tag));
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (rd_data !== e.d) begin
                    miscompares++;
                    $display("FAIL %s rd_data got %h expected %h", e.tag, rd_data, e.d);
                end
                if (rd_busy !== e.b) begin
                    miscompares++;
                    $display("FAIL %s rd_busy got %b expected %b", e.tag, rd_busy, e.b);
                end
                if (pending_cnt !== e.c) begin
                    miscompares++;
                    $display("FAIL %s pending_cnt got %0d expected %0d", e.tag, pending_cnt, e.c);
                end
            end
        end
    end

    initial begin
        exp_t e0;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; issue_en = 1'b0; issue_rd = '0;
        model_reset();

        // Reset contents spelled out directly rather than taken from the model.
        @(posedge clk);
        #1;
        rd_addr = {5'd2, 5'd0};
        e0.d = {32'h20, 32'h0}; e0.b = 2'b00; e0.c = '0; e0.tag = "reset_read";
        q.push_back(e0);

        step(0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, "wr_reg0");
        step(0, 1, 5, 32'h1234, 5, 0, 0, 0, "wr_reg5");
        step(0, 0, 0, 0, 5, 0, 0, 0, "rd_reg5");

        step(0, 0, 0, 0, 7, 9, 1, 7, "issue7");
        step(0, 0, 0, 0, 7, 9, 1, 9, "issue9");
        step(0, 0, 0, 0, 7, 9, 0, 0, "busy_7_9");
        step(0, 1, 7, 32'h77, 7, 9, 0, 0, "wb7");
        step(0, 0, 0, 0, 7, 9, 0, 0, "after_wb7");

        step(0, 1, 9, 32'h99, 9, 0, 1, 9, "same_9");
        step(0, 0, 0, 0, 9, 0, 0, 0, "after_same_9");
        step(0, 1, 9, 32'h999, 3, 9, 1, 3, "iss3_wb9");
        step(0, 0, 0, 0, 3, 9, 0, 0, "after_iss3_wb9");

        step(0, 1, 4, 32'hCAFE, 4, 0, 0, 0, "bypass4");
        step(0, 0, 0, 0, 4, 0, 0, 0, "after_bypass4");

        for (int i = 0; i < 400; i++) begin
            step(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                 AW'($urandom_range(0, 7)), AW'($urandom_range(0, NREGS - 1)),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), "random");
        end

        // Settle to a known busy set, then pulse reset mid-cycle.
        step(0, 0, 0, 0, 0, 0, 0, 0, "drain_a");
        for (int r = 1; r < NREGS; r++) begin
            step(0, 1, AW'(r), 32'h0, 0, 0, 0, 0, "clear");
        end
        step(0, 1, 5, 32'h1234, 5, 2, 1, 10, "pre_a");
        step(0, 0, 0, 0, 10, 5, 1, 11, "pre_b");
        step(0, 0, 0, 0, 11, 12, 1, 12, "pre_c");
        step(0, 0, 0, 0, 12, 5, 0, 0, "three_busy");

        drive(0, 1, 5, 32'hFFFF, 2, 5, 1, 13);
        #2;
        rst = 1'b1;
        model_reset();
        q.push_back(predict("rst_mid"));
        step(0, 0, 0, 0, 2, 5, 0, 0, "post_rst");
        step(0, 0, 0, 0, 13, 10, 0, 0, "post_rst_busy");

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain %0d expectations left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised integer register file for the pipelined RISC-V core; replaces the fixed 32x32 single-cycle file.
- Configurable data width, register count and number of read ports.
- Adds a per-register pending-write scoreboard with an in-flight counter, used by the decode stage for hazard detection.
- Sits between decode (reads, issue) and writeback (writes).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of two, >=4); AW = $clog2(NREGS).
- NREAD, 2, number of combinational read ports (1..4).
- SP_IDX, 2, index of the stack pointer register.
- SP_INIT, 32'h20, reset value of the stack pointer register.

Ports:
- clk  input  1  core clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  writeback write strobe.
- wr_addr  input  AW  writeback destination index.
- wr_data  input  XLEN  writeback data.
- rd_addr  input  NREAD*AW  packed read indices; port i is bits [i*AW +: AW].
- rd_data  output  NREAD*XLEN  packed read data, port i at [i*XLEN +: XLEN].
- rd_busy  output  NREAD  per-port flag: the addressed register has a pending write.
- issue_en  input  1  decode issued an instruction that will write issue_rd.
- issue_rd  input  AW  destination of the issued instruction.
- pending_cnt  output  AW+1  number of registers currently marked busy.

Behaviour:
- Reset (async, active-high, takes effect immediately, dominates everything):
  - all registers = 0, except reg[SP_IDX] = SP_INIT.
  - scoreboard cleared; pending_cnt = 0.
  - rd_data reflects the reset contents combinationally; rd_busy = 0.
- Reset asserted mid-operation discards any pending write or issue in that cycle.
- Register 0:
  - always reads 0; writes are ignored.
  - never marked busy; issue_rd = 0 has no effect.
- Write: on the rising edge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data. Visible on rd_data from the next cycle; same-cycle behaviour is set by the optional feature.
- Read: rd_data and rd_busy are combinational from rd_addr and current state; zero-latency. Multiple ports may address the same register.
- Scoreboard, per rising edge:
  - issue_en=1 and issue_rd!=0: busy[issue_rd] <= 1.
  - wr_en=1 and wr_addr!=0: busy[wr_addr] <= 0.
  - Same non-zero address for both: set wins (new producer supersedes the completing one); busy stays 1.
  - Issue to an already-busy register: stays busy, no count change.
  - Write to a non-busy register: data written, busy unchanged, no count change.
- pending_cnt tracks the number of set busy bits:
  - +1 when a 0->1 transition occurs.
  - -1 when a 1->0 transition occurs.
  - unchanged when one register goes 0->1 and another 1->0 in the same cycle.
  - Never exceeds NREGS-1; never underflows.
- Only one issue and one write per cycle.

Optional Feature:
- Macro: PARAM_REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding on the same cycle. For each port i with wr_en=1, wr_addr!=0 and rd_addr_i==wr_addr:
  - rd_data_i = wr_data.
  - rd_busy_i = 0, unless issue_en=1 and issue_rd==wr_addr in the same cycle, in which case rd_busy_i = 1.
- Undefined: rd_data and rd_busy always reflect stored state only; a write is readable only in the cycle after its edge.

Test Plan:
- Reset then read: rd_addr = {2, 0} -> rd_data = {32'h20, 0}; rd_busy = 0; pending_cnt = 0.
- Write reg0 and reg5: write 32'hDEADBEEF to reg0 and 32'h1234 to reg5 -> reg0 reads 0; reg5 reads 32'h1234 on the next cycle.
- Issue/writeback sequence: issue rd=7, then rd=9 -> pending_cnt = 2 and rd_busy set for 7 and 9. Write 7 -> pending_cnt = 1, busy[7] = 0.
- Simultaneous events: issue_rd = wr_addr = 9 on the same edge -> busy[9] stays 1 and pending_cnt is unchanged. Issue 3 plus write 9 on the same edge -> count unchanged, busy[3] = 1, busy[9] = 0.
- Bypass, write 32'hCAFE to reg4 while port1 reads reg4:
  - With PARAM_REGFILE_BYPASS_EN: same-cycle rd_data1 = 32'hCAFE.
  - Without it: same-cycle rd_data1 = old value; 32'hCAFE the following cycle.
- Async reset mid-run: with 3 registers busy and reg5 = 32'h1234, pulse rst between edges -> outputs clear immediately; pending_cnt = 0; reg5 reads 0; reg2 reads 32'h20.
